atmos_light_est: RTL and testbench

//  Per-frame atmospheric-light (A) estimator; producer of the pre_A value consumed by the haze-removal calc stage.

---
 rtl/atmos_light_est.sv | 152 +++++++++++++++
 tb/tb_atmos_light_est.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atmos_light_est.sv
// Per-frame atmospheric-light estimator.
// Scans each frame's RGB stream alongside its dark-channel value. The candidate A
// is the largest max(R,G,B) over the pixels whose dark value lies within DELTA of
// the previous frame's dark maximum. That candidate is IIR-smoothed across frames,
// clamped, and held constant for the whole next frame.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pre_frame_vsync   frame valid (high for the whole active frame)
//   pre_frame_href    line valid
//   pre_frame_clken   pixel strobe; a pixel is sampled when href & clken
//   pre_img[23:0]     {R,G,B}, 8 bits each
//   pre_dark[7:0]     dark-channel value aligned with pre_img
//   post_A[7:0]       current atmospheric light, stable between updates
//   post_A_valid      one-cycle pulse when post_A is (re)issued at frame end
//   post_dark_max     max pre_dark of the last completed frame
module atmos_light_est #(
  parameter logic [7:0]  DELTA        = 8'd16,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter logic [7:0]  A_MIN        = 8'd64,
  parameter logic [7:0]  A_MAX        = 8'd240,
  parameter logic [7:0]  A_INIT       = 8'd200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_href,
  input  logic        pre_frame_clken,
  input  logic [23:0] pre_img,
  input  logic [7:0]  pre_dark,
  output logic [7:0]  post_A,
  output logic        post_A_valid,
  output logic [7:0]  post_dark_max
);

  localparam int unsigned PW = 8;
  localparam int unsigned AW = 10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  logic [1:0]           state, state_nxt;
  logic                 vsync_d1;
  logic                 rise, fall;
  logic                 pending;
  logic                 start;
  logic                 sample;
  logic [PW-1:0]        thr, thr_next;
  logic [PW-1:0]        dmax, cand;
  logic                 hit, first_done;
  logic [PW-1:0]        pix_r, pix_g, pix_b, pix_max;
  logic signed [AW-1:0] diff, a_iir, a_new;
  logic [PW-1:0]        a_clamped;

  assign rise   = pre_frame_vsync & ~vsync_d1;
  assign fall   = ~pre_frame_vsync & vsync_d1;
  // A rise seen during UPDATE is parked in pending and starts the frame from IDLE.
  assign start  = (state == S_IDLE) & (rise | pending);
  // vsync is already low on the fall cycle, so that cycle's pixel is excluded.
  assign sample = (state == S_ACCUM) & pre_frame_vsync & pre_frame_href & pre_frame_clken;

  assign pix_r = pre_img[23:16];
  assign pix_g = pre_img[15:8];
  assign pix_b = pre_img[7:0];

  // Brightest colour component of the current pixel.
  always_comb begin
    pix_max = pix_r;
    if (pix_g > pix_max) pix_max = pix_g;
    if (pix_b > pix_max) pix_max = pix_b;
  end

  // Qualification threshold for the next frame, floored at zero.
  always_comb begin
    thr_next = '0;
    if (post_dark_max > DELTA) thr_next = post_dark_max - DELTA;
  end

  // IIR step in 10-bit signed arithmetic, then clamp to [A_MIN, A_MAX].
  always_comb begin
    diff  = $signed({2'b00, cand}) - $signed({2'b00, post_A});
    a_iir = $signed({2'b00, post_A}) + (diff >>> SMOOTH_SHIFT);
    a_new = first_done ? a_iir : $signed({2'b00, cand});
    if (a_new < $signed({2'b00, A_MIN}))
      a_clamped = A_MIN;
    else if (a_new > $signed({2'b00, A_MAX}))
      a_clamped = A_MAX;
    else
      a_clamped = a_new[PW-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (rise | pending) state_nxt = S_ACCUM;
      S_ACCUM:  if (fall) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Frame accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1      <= 1'b1;
      pending       <= 1'b0;
      thr           <= '0;
      dmax          <= '0;
      cand          <= '0;
      hit           <= 1'b0;
      first_done    <= 1'b0;
      post_A        <= A_INIT;
      post_A_valid  <= 1'b0;
      post_dark_max <= '0;
    end else begin
      vsync_d1     <= pre_frame_vsync;
      post_A_valid <= 1'b0;
      if (start) begin
        pending <= 1'b0;
        thr     <= thr_next;
        dmax    <= '0;
        cand    <= '0;
        hit     <= 1'b0;
      end else if ((state == S_UPDATE) && rise) begin
        pending <= 1'b1;
      end
      if (sample) begin
        if (pre_dark > dmax) dmax <= pre_dark;
        if (pre_dark >= thr) begin
          hit <= 1'b1;
          if (pix_max > cand) cand <= pix_max;
        end
      end
      if (state == S_UPDATE) begin
        post_dark_max <= dmax;
        post_A_valid  <= 1'b1;
        if (hit) begin
          post_A     <= a_clamped;
          first_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_atmos_light_est.sv
// Testbench for atmos_light_est: directed and randomized frames checked against
// a frame-level reference model (whole-frame max/threshold scan, floor-division IIR).
module tb_atmos_light_est;

  logic        clk;
  logic        rst_n;
  logic        pre_frame_vsync;
  logic        pre_frame_href;
  logic        pre_frame_clken;
  logic [23:0] pre_img;
  logic [7:0]  pre_dark;
  logic [7:0]  post_A;
  logic        post_A_valid;
  logic [7:0]  post_dark_max;

  atmos_light_est dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pre_frame_vsync (pre_frame_vsync),
    .pre_frame_href  (pre_frame_href),
    .pre_frame_clken (pre_frame_clken),
    .pre_img         (pre_img),
    .pre_dark        (pre_dark),
    .post_A          (post_A),
    .post_A_valid    (post_A_valid),
    .post_dark_max   (post_dark_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Reference model state.
  int m_A;
  int m_dm;
  int m_first;

  // Current frame contents.
  int          fr_n;
  logic [23:0] fr_rgb [64];
  logic [7:0]  fr_dark[64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int max3(input logic [23:0] rgb);
    int m = 0;
    for (int k = 0; k < 3; k++) begin
      int c = int'((rgb >> (8 * k)) & 24'hFF);
      if (c > m) m = c;
    end
    return m;
  endfunction

  function automatic int floor_div4(input int d);
    return (d >= 0) ? d / 4 : -((-d + 3) / 4);
  endfunction

  task automatic model_reset();
    m_A = 200;
    m_dm = 0;
    m_first = 0;
  endtask

  // Whole-frame reference: threshold from last frame, scan, smooth, clamp.
  task automatic model_frame(output int exp_A, output int exp_dm);
    int thr;
    int dmax;
    int cand;
    int a;
    bit hit;
    thr  = (m_dm > 16) ? m_dm - 16 : 0;
    dmax = 0;
    cand = 0;
    hit  = 1'b0;
    for (int i = 0; i < fr_n; i++) begin
      int d = int'(fr_dark[i]);
      if (d > dmax) dmax = d;
      if (d >= thr) begin
        hit = 1'b1;
        if (max3(fr_rgb[i]) > cand) cand = max3(fr_rgb[i]);
      end
    end
    if (hit) begin
      a = m_first ? m_A + floor_div4(cand - m_A) : cand;
      if (a < 64) a = 64;
      if (a > 240) a = 240;
      m_A = a;
      m_first = 1;
    end
    m_dm = dmax;
    exp_A = m_A;
    exp_dm = m_dm;
  endtask

  task automatic fill(input int n, input logic [7:0] dark, input logic [23:0] rgb);
    fr_n = n;
    for (int i = 0; i < n; i++) begin
      fr_dark[i] = dark;
      fr_rgb[i]  = rgb;
    end
  endtask

  task automatic fill_random(input int n, input int dlo, input int dhi);
    fr_n = n;
    for (int i = 0; i < n; i++) begin
      fr_dark[i] = 8'($urandom_range(dhi, dlo));
      fr_rgb[i]  = 24'($urandom);
    end
  endtask

  task automatic check_stable(input string tag);
    chk({tag, "_valid"}, 32'(post_A_valid), 32'd0);
    chk({tag, "_A"}, 32'(post_A), 32'(m_A));
    chk({tag, "_dm"}, 32'(post_dark_max), 32'(m_dm));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_A", 32'(post_A), 32'd200);
    chk("rst_valid", 32'(post_A_valid), 32'd0);
    chk("rst_dm", 32'(post_dark_max), 32'd0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Drives the stored frame with random href/clken gaps; ends with vsync driven low.
  task automatic send_frame(input bit already_high);
    int i;
    int r;
    pre_frame_vsync = 1'b1;
    pre_frame_href  = 1'b0;
    pre_frame_clken = 1'b0;
    repeat (4) begin
      tick();
      check_stable("idle");
    end
    i = 0;
    while (i < fr_n) begin
      r = int'($urandom_range(3, 0));
      pre_img  = 24'($urandom);
      pre_dark = 8'hFF;
      if (r == 0) begin
        pre_frame_href  = 1'b1;
        pre_frame_clken = 1'b0;
      end else if (r == 1) begin
        pre_frame_href  = 1'b0;
        pre_frame_clken = 1'b1;
      end else begin
        pre_frame_href  = 1'b1;
        pre_frame_clken = 1'b1;
        pre_img  = fr_rgb[i];
        pre_dark = fr_dark[i];
        i++;
      end
      tick();
      check_stable("accum");
    end
    pre_frame_href  = 1'b0;
    pre_frame_clken = 1'b0;
    tick();
    tick();
    // Bright pixel on the fall cycle must not be accumulated.
    pre_frame_vsync = 1'b0;
    pre_frame_href  = 1'b1;
    pre_frame_clken = 1'b1;
    pre_img  = 24'hFFFFFF;
    pre_dark = 8'hFF;
    if (already_high) pre_frame_vsync = 1'b0;
  endtask

  task automatic check_update(input bit raise_next, input int exp_A, input int exp_dm, input int old_A);
    tick();
    pre_frame_href  = 1'b0;
    pre_frame_clken = 1'b0;
    if (raise_next) pre_frame_vsync = 1'b1;
    chk("pre_pulse_valid", 32'(post_A_valid), 32'd0);
    chk("pre_pulse_A", 32'(post_A), 32'(old_A));
    tick();
    chk("pulse", 32'(post_A_valid), 32'd1);
    chk("post_A", 32'(post_A), 32'(exp_A));
    chk("dark_max", 32'(post_dark_max), 32'(exp_dm));
    tick();
    chk("pulse_end", 32'(post_A_valid), 32'd0);
    chk("A_hold", 32'(post_A), 32'(exp_A));
  endtask

  task automatic do_frame(input bit already_high, input bit raise_next);
    int old_A;
    int e_A;
    int e_dm;
    old_A = m_A;
    send_frame(already_high);
    model_frame(e_A, e_dm);
    check_update(raise_next, e_A, e_dm, old_A);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    pre_frame_vsync = 1'b0;
    pre_frame_href  = 1'b0;
    pre_frame_clken = 1'b0;
    pre_img  = '0;
    pre_dark = '0;
    model_reset();
    tick();
    do_reset();

    // Frame 1: first frame takes the candidate directly.
    fill(16, 8'd50, {8'd100, 8'd100, 8'd100});
    fr_rgb[5] = {8'd230, 8'd10, 8'd10};
    do_frame(1'b0, 1'b0);

    // Frame 2: smoothing toward 130 from 230.
    fill(16, 8'd60, {8'd120, 8'd80, 8'd40});
    fr_rgb[9] = {8'd130, 8'd20, 8'd5};
    do_frame(1'b0, 1'b0);

    // Frame 3 raises dark max to 200; frame 4 then has no qualifying pixel.
    fill_random(12, 0, 200);
    fr_dark[0] = 8'd200;
    do_frame(1'b0, 1'b0);
    fill(16, 8'd10, {8'd250, 8'd250, 8'd250});
    do_frame(1'b0, 1'b0);

    // Empty frame.
    fr_n = 0;
    do_frame(1'b0, 1'b0);

    // Randomized frames, the last pair back-to-back with a one-cycle vsync gap.
    for (int k = 0; k < 6; k++) begin
      int lo = int'($urandom_range(150, 0));
      fill_random(int'($urandom_range(20, 4)), lo, lo + 60);
      do_frame(k == 5, k == 4);
    end

    // Clamp high and low on a first frame.
    do_reset();
    fill(8, 8'd40, {8'd20, 8'd250, 8'd100});
    do_frame(1'b0, 1'b0);
    do_reset();
    fill(8, 8'd40, {8'd30, 8'd12, 8'd25});
    do_frame(1'b0, 1'b0);

    // Reset asserted and released while vsync is high: that frame is ignored.
    pre_frame_vsync = 1'b1;
    repeat (3) tick();
    pre_frame_href = 1'b1;
    pre_frame_clken = 1'b1;
    pre_img = 24'hF0F0F0;
    pre_dark = 8'd90;
    repeat (3) tick();
    do_reset();
    repeat (4) tick();
    pre_frame_vsync = 1'b0;
    pre_frame_href = 1'b0;
    pre_frame_clken = 1'b0;
    repeat (6) begin
      tick();
      check_stable("partial");
    end
    // Next full frame behaves as a first frame again.
    fill(10, 8'd30, {8'd150, 8'd60, 8'd70});
    do_frame(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
